// File: rtl/fpu_divider_sp.sv
// Sequential IEEE-754 single-precision divider: restoring mantissa division, one quotient bit per clock.
// Build option: define FPU_DIV_ROUND_EN for round-to-nearest-even; otherwise the quotient is truncated.
module fpu_divider_sp #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy,
  output logic             div_by_zero,
  output logic             invalid,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {IDLE, DIVIDE, NORM, SPECIAL} state_t;

  state_t             state, state_nxt;
  logic [4:0]         iter;
  logic [31:0]        a_r, b_r;
  logic [24:0]        rem;
  logic [25:0]        quo;
  logic signed [9:0]  exp_r;

  logic [23:0]        mb;
  logic [25:0]        diff;
  logic               q_bit;
  logic [24:0]        rem_sel;

  logic [22:0]        mant_n;
  logic signed [9:0]  exp_n;
  logic [23:0]        mant_rnd;
  logic signed [9:0]  exp_f;
`ifdef FPU_DIV_ROUND_EN
  logic               guard_n;
  logic               sticky_n;
`endif

  logic [31:0]        fin_res;
  logic [3:0]         fin_flags;
  logic [33:0]        norm_pack;

  // Every operand with exponent 0 or 255 (zero, denormal, Inf, NaN) bypasses the divider.
  function automatic logic is_special(input logic [31:0] a, input logic [31:0] b);
    return (a[30:23] == 8'h00) || (a[30:23] == 8'hFF) ||
           (b[30:23] == 8'h00) || (b[30:23] == 8'hFF);
  endfunction

  // Returns {div_by_zero, invalid, overflow, underflow, result}.
  function automatic logic [35:0] special_case(input logic [31:0] a, input logic [31:0] b);
    logic s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    s      = a[31] ^ b[31];
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    a_zero = (a[30:23] == 8'h00);
    b_zero = (b[30:23] == 8'h00);
    if (a_nan || b_nan)                         return {4'b0000, QNAN};
    else if ((a_zero && b_zero) || (a_inf && b_inf)) return {4'b0100, QNAN};
    else if (a_inf)                             return {4'b0000, s, 8'hFF, 23'd0};
    else if (b_zero)                            return {4'b1000, s, 8'hFF, 23'd0};
    else                                        return {4'b0000, s, 31'd0};
  endfunction

`ifdef FPU_DIV_ROUND_EN
  // Nearest-even increment; bit 23 of the return is the mantissa carry-out.
  function automatic logic [23:0] round_rne(input logic [22:0] m, input logic g, input logic s);
    return {1'b0, m} + {23'd0, g & (s | m[0])};
  endfunction
`endif

  // Applies the exponent range limits; returns {overflow, underflow, result}.
  function automatic logic [33:0] saturate(input logic s, input logic signed [9:0] e,
                                           input logic [22:0] m);
    if (e >= 10'sd255)     return {2'b10, s, 8'hFF, 23'd0};
    else if (e <= 10'sd0)  return {2'b01, s, 31'd0};
    else                   return {2'b00, s, e[7:0], m};
  endfunction

  assign busy = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = is_special(A, B) ? SPECIAL : DIVIDE;
      DIVIDE:  if (iter == 5'd25) state_nxt = NORM;
      NORM:    state_nxt = IDLE;
      SPECIAL: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One restoring step: trial subtract, keep the difference when it does not borrow.
  always_comb begin
    mb      = {1'b1, b_r[22:0]};
    diff    = {1'b0, rem} - {2'b00, mb};
    q_bit   = ~diff[25];
    rem_sel = q_bit ? diff[24:0] : rem;
  end

  always_comb begin
    mant_n = quo[25] ? quo[24:2] : quo[23:1];
    exp_n  = quo[25] ? exp_r : exp_r - 10'sd1;
`ifdef FPU_DIV_ROUND_EN
    guard_n  = quo[25] ? quo[1] : quo[0];
    sticky_n = (quo[25] & quo[0]) | (|rem);
    mant_rnd = round_rne(mant_n, guard_n, sticky_n);
`else
    mant_rnd = {1'b0, mant_n};
`endif
    exp_f     = exp_n + $signed({9'd0, mant_rnd[23]});
    norm_pack = saturate(a_r[31] ^ b_r[31], exp_f, mant_rnd[22:0]);
  end

  always_comb begin
    fin_res   = 32'd0;
    fin_flags = 4'd0;
    if (state == SPECIAL) begin
      {fin_flags, fin_res} = special_case(a_r, b_r);
    end else begin
      fin_res   = norm_pack[31:0];
      fin_flags = {2'b00, norm_pack[33:32]};
    end
  end

  // Control and architecturally visible outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      iter        <= 5'd0;
      done        <= 1'b0;
      result      <= 32'd0;
      div_by_zero <= 1'b0;
      invalid     <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      if (state == IDLE && start) iter <= 5'd0;
      else if (state == DIVIDE)   iter <= iter + 5'd1;
      if (state == NORM || state == SPECIAL) begin
        done   <= 1'b1;
        result <= fin_res;
        {div_by_zero, invalid, overflow, underflow} <= fin_flags;
      end
    end
  end

  // Operand capture and the iterating remainder/quotient
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      a_r   <= A;
      b_r   <= B;
      rem   <= {1'b0, 1'b1, A[22:0]};
      exp_r <= $signed({2'b00, A[30:23]}) - $signed({2'b00, B[30:23]}) + 10'sd127;
    end else if (state == DIVIDE) begin
      rem <= {rem_sel[23:0], 1'b0};
      quo <= {quo[24:0], q_bit};
    end
  end

endmodule

// File: tb/tb_fpu_divider_sp.sv
// Self-checking bench for fpu_divider_sp: directed cases plus random operands against an arithmetic model.
module tb_fpu_divider_sp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] op_a = 32'd0, op_b = 32'd0;
  logic [31:0] result;
  logic        done, busy, div_by_zero, invalid, overflow, underflow;

  int checks = 0;
  int errors = 0;

  fpu_divider_sp #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(op_a), .B(op_b),
    .result(result), .done(done), .busy(busy),
    .div_by_zero(div_by_zero), .invalid(invalid),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: one integer division of the scaled mantissas, then the normalise/round/range rules.
  // flags = {div_by_zero, invalid, overflow, underflow}; lat = negedges from acceptance to done.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic [3:0] f, output int lat);
    logic        s;
    int          ea, eb, e;
    bit          an, bn, ai, bi, az, bz;
    logic [63:0] ma, mbv, q, rm;
    logic [23:0] mant;
`ifdef FPU_DIV_ROUND_EN
    bit          g, st;
`endif
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    an = (ea == 255) && (a[22:0] != 0);
    bn = (eb == 255) && (b[22:0] != 0);
    ai = (ea == 255) && (a[22:0] == 0);
    bi = (eb == 255) && (b[22:0] == 0);
    az = (ea == 0);
    bz = (eb == 0);
    f = 4'b0000;
    lat = 2;
    if (an || bn) r = 32'h7FC00000;
    else if ((az && bz) || (ai && bi)) begin r = 32'h7FC00000; f = 4'b0100; end
    else if (ai) r = {s, 8'hFF, 23'd0};
    else if (bz) begin r = {s, 8'hFF, 23'd0}; f = 4'b1000; end
    else if (az || bi) r = {s, 31'd0};
    else begin
      lat = 28;
      ma  = {40'd0, 1'b1, a[22:0]};
      mbv = {40'd0, 1'b1, b[22:0]};
      q   = (ma << 25) / mbv;
      rm  = (ma << 25) % mbv;
      e   = ea - eb + 127;
      if (q[25]) begin
        mant = {1'b0, q[24:2]};
`ifdef FPU_DIV_ROUND_EN
        g  = q[1];
        st = q[0] || (rm != 0);
`endif
      end else begin
        mant = {1'b0, q[23:1]};
        e    = e - 1;
`ifdef FPU_DIV_ROUND_EN
        g  = q[0];
        st = (rm != 0);
`endif
      end
`ifdef FPU_DIV_ROUND_EN
      if (g && (st || mant[0])) mant = mant + 24'd1;
      if (mant[23]) begin mant = 24'd0; e = e + 1; end
`endif
      if (e >= 255)     begin r = {s, 8'hFF, 23'd0}; f = 4'b0010; end
      else if (e <= 0)  begin r = {s, 31'd0};        f = 4'b0001; end
      else r = {s, e[7:0], mant[22:0]};
    end
  endfunction

  // chain=1: caller is in a done cycle and the new start is presented right there.
  // intrude=1: a second start with other operands is pulsed mid-operation.
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input bit chain, input bit intrude);
    logic [31:0] er;
    logic [3:0]  ef;
    int          el, n;
    model(a, b, er, ef, el);
    if (!chain) @(negedge clk);
    op_a = a; op_b = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    check({tag, ".busy"}, {31'd0, busy}, 32'd1);
    if (intrude) begin
      repeat (4) begin @(negedge clk); n++; end
      op_a = 32'h7FC00000; op_b = 32'h00000000; start = 1'b1;
      @(negedge clk); n++;
      start = 1'b0;
    end
    while (!done && n < 60) begin @(negedge clk); n++; end
    check({tag, ".lat"}, n, el);
    check({tag, ".res"}, result, er);
    check({tag, ".flags"}, {28'd0, div_by_zero, invalid, overflow, underflow}, {28'd0, ef});
    check({tag, ".busy_at_done"}, {31'd0, busy}, 32'd0);
  endtask

  function automatic logic [31:0] rnd_fp();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 9))
      0: v[30:23] = 8'h00;
      1: v[30:23] = 8'hFF;
      2: begin v[30:23] = 8'hFF; v[22:0] = 23'd0; end
      3: v[30:23] = 8'($urandom_range(250, 254));
      4: v[30:23] = 8'($urandom_range(1, 5));
      default: ;
    endcase
    return v;
  endfunction

  initial begin
    int dn;
    repeat (3) @(negedge clk);
    check("rst.result", result, 32'd0);
    check("rst.done_busy", {30'd0, done, busy}, 32'd0);
    check("rst.flags", {28'd0, div_by_zero, invalid, overflow, underflow}, 32'd0);
    rst_n = 1'b1;

    do_op("6div2", 32'h40C00000, 32'h40000000, 1'b0, 1'b0);
    @(negedge clk);
    check("6div2.pulse", {31'd0, done}, 32'd0);
`ifdef FPU_DIV_ROUND_EN
    check("1div3.ref", 32'h3EAAAAAB, 32'h3EAAAAAB ^ 32'd0);
`endif
    do_op("1div3", 32'h3F800000, 32'h40400000, 1'b0, 1'b0);
    do_op("m1div0", 32'hBF800000, 32'h00000000, 1'b0, 1'b0);
    do_op("0div0", 32'h00000000, 32'h00000000, 1'b0, 1'b0);
    do_op("nan", 32'h7FC00000, 32'h3F800000, 1'b0, 1'b0);
    do_op("ovf", 32'h7F000000, 32'h00800000, 1'b0, 1'b0);
    do_op("unf", 32'h00800000, 32'h7F000000, 1'b0, 1'b0);
    do_op("intrude", 32'h3F800000, 32'h40400000, 1'b0, 1'b1);
    do_op("chain1", 32'hC1200000, 32'h40A00000, 1'b1, 1'b0);
    do_op("chain2", 32'h7F800000, 32'h3F800000, 1'b1, 1'b0);
    do_op("chain3", 32'h3FC00000, 32'hBF400000, 1'b1, 1'b0);

    // Leave a nonzero result and a raised flag, then abort a divide with reset.
    do_op("pre_rst", 32'h7F000000, 32'h00800000, 1'b0, 1'b0);
    @(negedge clk);
    op_a = 32'h3F800000; op_b = 32'h40400000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst.busy", {31'd0, busy}, 32'd0);
    check("midrst.result", result, 32'd0);
    check("midrst.flags", {28'd0, div_by_zero, invalid, overflow, underflow}, 32'd0);
    rst_n = 1'b1;
    dn = 0;
    repeat (40) begin @(negedge clk); if (done) dn++; end
    check("midrst.no_done", dn, 0);

    for (int i = 0; i < 60; i++) begin
      do_op($sformatf("rnd%0d", i), rnd_fp(), rnd_fp(), 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
